regfile_wr_arbiter: RTL and testbench



---
 rtl/regfile_wr_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
// Shares the register file's single write port between NUMREQ producers with
// round-robin valid/ready arbitration, registers the winning write for one
// cycle, and keeps a per-register busy scoreboard for RAW hazard stalls.
// Optional feature: define REGFILE_WR_ARB_GRANT_CNT_EN to add per-requester
// saturating grant counters (grant_cnt) with a synchronous clear (grant_cnt_clr).
module regfile_wr_arbiter #(
  parameter int NUMREGISTERS = 8,
  parameter int DATAW = 32,
  parameter int NUMREQ = 3,
  localparam int REGW = $clog2(NUMREGISTERS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUMREQ-1:0]         req_valid,
  input  logic [NUMREQ*REGW-1:0]    req_reg,
  input  logic [NUMREQ*DATAW-1:0]   req_data,
  output logic [NUMREQ-1:0]         req_ready,
  input  logic                      rsv_en,
  input  logic [REGW-1:0]           rsv_reg,
  input  logic [REGW-1:0]           chk_reg1,
  input  logic [REGW-1:0]           chk_reg2,
  output logic                      chk_busy1,
  output logic                      chk_busy2,
  output logic [NUMREGISTERS-1:0]   busy,
  output logic                      wr_reg_en,
  output logic [REGW-1:0]           wr_reg,
  output logic [DATAW-1:0]          wr_reg_data
`ifdef REGFILE_WR_ARB_GRANT_CNT_EN
  ,
  input  logic                      grant_cnt_clr,
  output logic [NUMREQ*16-1:0]      grant_cnt
`endif
);

  localparam int PTRW = (NUMREQ > 1) ? $clog2(NUMREQ) : 1;

  logic [PTRW-1:0]  rr_ptr;
  logic [PTRW-1:0]  grant_idx;
  logic             grant_any;
  logic [REGW-1:0]  sel_reg;
  logic [DATAW-1:0] sel_data;

  // Scan requesters from rr_ptr upward with wrap; the first valid one wins.
  always_comb begin
    int idx;
    req_ready = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    sel_reg   = '0;
    sel_data  = '0;
    idx       = 0;
    if (rst_n) begin
      for (int k = 0; k < NUMREQ; k++) begin
        idx = (int'(rr_ptr) + k) % NUMREQ;
        if (!grant_any && req_valid[idx]) begin
          grant_any      = 1'b1;
          grant_idx      = PTRW'(idx);
          req_ready[idx] = 1'b1;
          sel_reg        = req_reg[idx*REGW +: REGW];
          sel_data       = req_data[idx*DATAW +: DATAW];
        end
      end
    end
  end

  // Round-robin pointer moves just past the requester that transferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (int'(grant_idx) == NUMREQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  // Register the winning write; index and data hold when nothing transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_reg_en   <= 1'b0;
      wr_reg      <= '0;
      wr_reg_data <= '0;
    end else begin
      wr_reg_en <= grant_any;
      if (grant_any) begin
        wr_reg      <= sel_reg;
        wr_reg_data <= sel_data;
      end
    end
  end

  // Busy scoreboard: a new reservation beats a same-cycle writeback clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int r = 0; r < NUMREGISTERS; r++) begin
        if (rsv_en && rsv_reg == REGW'(r)) begin
          busy[r] <= 1'b1;
        end else if (wr_reg_en && wr_reg == REGW'(r)) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  // Hazard check; a register written this cycle is forwarded, so not busy.
  always_comb begin
    logic hit1;
    logic hit2;
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int r = 0; r < NUMREGISTERS; r++) begin
      if (chk_reg1 == REGW'(r)) hit1 = busy[r];
      if (chk_reg2 == REGW'(r)) hit2 = busy[r];
    end
    chk_busy1 = hit1 & ~(wr_reg_en & (wr_reg == chk_reg1));
    chk_busy2 = hit2 & ~(wr_reg_en & (wr_reg == chk_reg2));
  end

`ifdef REGFILE_WR_ARB_GRANT_CNT_EN
  // Saturating per-requester grant counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUMREQ; i++) begin
        if (grant_cnt_clr) begin
          grant_cnt[i*16 +: 16] <= 16'h0000;
        end else if (grant_any && int'(grant_idx) == i && grant_cnt[i*16 +: 16] != 16'hFFFF) begin
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'h0001;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter
// Directed scenarios plus randomized traffic, every cycle compared against a
// behavioural model of arbitration, write latency and the busy scoreboard.
// Build with REGFILE_WR_ARB_GRANT_CNT_EN defined to exercise the grant counters.
module tb_regfile_wr_arbiter;

  localparam int NUMREGISTERS = 8;
  localparam int DATAW = 32;
  localparam int NUMREQ = 3;
  localparam int REGW = 3;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUMREQ-1:0]       req_valid = '0;
  logic [NUMREQ*REGW-1:0]  req_reg = '0;
  logic [NUMREQ*DATAW-1:0] req_data = '0;
  logic [NUMREQ-1:0]       req_ready;
  logic                    rsv_en = 1'b0;
  logic [REGW-1:0]         rsv_reg = '0;
  logic [REGW-1:0]         chk_reg1 = '0;
  logic [REGW-1:0]         chk_reg2 = '0;
  logic                    chk_busy1;
  logic                    chk_busy2;
  logic [NUMREGISTERS-1:0] busy;
  logic                    wr_reg_en;
  logic [REGW-1:0]         wr_reg;
  logic [DATAW-1:0]        wr_reg_data;
`ifdef REGFILE_WR_ARB_GRANT_CNT_EN
  logic                    grant_cnt_clr = 1'b0;
  logic [NUMREQ*16-1:0]    grant_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  int               m_ptr;
  bit               m_busy [NUMREGISTERS];
  bit               m_wen;
  int               m_wreg;
  logic [DATAW-1:0] m_wdata;

  regfile_wr_arbiter #(
    .NUMREGISTERS(NUMREGISTERS),
    .DATAW(DATAW),
    .NUMREQ(NUMREQ)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_reg(req_reg),
    .req_data(req_data),
    .req_ready(req_ready),
    .rsv_en(rsv_en),
    .rsv_reg(rsv_reg),
    .chk_reg1(chk_reg1),
    .chk_reg2(chk_reg2),
    .chk_busy1(chk_busy1),
    .chk_busy2(chk_busy2),
    .busy(busy),
    .wr_reg_en(wr_reg_en),
    .wr_reg(wr_reg),
    .wr_reg_data(wr_reg_data)
`ifdef REGFILE_WR_ARB_GRANT_CNT_EN
    ,
    .grant_cnt_clr(grant_cnt_clr),
    .grant_cnt(grant_cnt)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    m_ptr = 0;
    m_wen = 1'b0;
    m_wreg = 0;
    m_wdata = '0;
    for (int r = 0; r < NUMREGISTERS; r++) m_busy[r] = 1'b0;
  endtask

  function automatic logic [NUMREGISTERS-1:0] busyVec();
    logic [NUMREGISTERS-1:0] v;
    for (int r = 0; r < NUMREGISTERS; r++) v[r] = m_busy[r];
    return v;
  endfunction

  // Drive one cycle of inputs, check all outputs against the model, then
  // advance the model to the state after the coming clock edge.
  task automatic applyStimulus(input logic [NUMREQ-1:0] v, input logic [NUMREQ*REGW-1:0] r,
                               input logic [NUMREQ*DATAW-1:0] d, input logic re,
                               input logic [REGW-1:0] rr, input logic [REGW-1:0] c1,
                               input logic [REGW-1:0] c2, output int g);
    @(negedge clk);
    req_valid = v;
    req_reg   = r;
    req_data  = d;
    rsv_en    = re;
    rsv_reg   = rr;
    chk_reg1  = c1;
    chk_reg2  = c2;
    #1;
    g = -1;
    for (int k = 0; k < NUMREQ; k++) begin
      if (g < 0 && v[(m_ptr + k) % NUMREQ]) g = (m_ptr + k) % NUMREQ;
    end
    checkOutput("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
    checkOutput("wr_reg_en", wr_reg_en, m_wen);
    checkOutput("wr_reg", wr_reg, m_wreg);
    checkOutput("wr_reg_data", wr_reg_data, m_wdata);
    checkOutput("busy", busy, busyVec());
    checkOutput("chk_busy1", chk_busy1, m_busy[c1] && !(m_wen && m_wreg == int'(c1)));
    checkOutput("chk_busy2", chk_busy2, m_busy[c2] && !(m_wen && m_wreg == int'(c2)));
    if (m_wen) m_busy[m_wreg] = 1'b0;
    if (re) m_busy[rr] = 1'b1;
    m_wen = (g >= 0);
    if (g >= 0) begin
      m_wreg  = int'(r[g*REGW +: REGW]);
      m_wdata = d[g*DATAW +: DATAW];
      m_ptr   = (g + 1) % NUMREQ;
    end
  endtask

  initial begin
    int g;
    logic [NUMREQ-1:0]       cv;
    logic [NUMREQ*REGW-1:0]  cr;
    logic [NUMREQ*DATAW-1:0] cd;
    logic [NUMREQ*REGW-1:0]  rr3;
    logic [NUMREQ*DATAW-1:0] dd3;

    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state with idle inputs.
    applyStimulus(3'b000, '0, '0, 1'b0, 3'd0, 3'd0, 3'd0, g);

    // Round-robin with all three valid: regs 1,2,3 and data A,B,C.
    rr3 = {3'd3, 3'd2, 3'd1};
    dd3 = {32'hC, 32'hB, 32'hA};
    for (int k = 0; k < 6; k++) begin
      applyStimulus(3'b111, rr3, dd3, 1'b0, 3'd0, 3'd0, 3'd0, g);
      checkOutput("rr_grant", req_ready, 64'd1 << (k % 3));
    end

    // Single streaming requester 2 writing reg 5 twice.
    rr3 = {3'd5, 3'd0, 3'd0};
    applyStimulus(3'b100, rr3, {32'h11, 32'h0, 32'h0}, 1'b0, 3'd0, 3'd0, 3'd0, g);
    checkOutput("single_ready1", req_ready, 3'b100);
    applyStimulus(3'b100, rr3, {32'h22, 32'h0, 32'h0}, 1'b0, 3'd0, 3'd0, 3'd0, g);
    checkOutput("single_ready2", req_ready, 3'b100);
    checkOutput("single_data1", wr_reg_data, 32'h11);
    applyStimulus(3'b000, '0, '0, 1'b0, 3'd0, 3'd0, 3'd0, g);
    checkOutput("single_data2", wr_reg_data, 32'h22);
    checkOutput("single_reg", wr_reg, 3'd5);

    // Scoreboard: reserve reg 4, requester 1 writes it back.
    applyStimulus(3'b000, '0, '0, 1'b1, 3'd4, 3'd0, 3'd0, g);
    applyStimulus(3'b000, '0, '0, 1'b0, 3'd0, 3'd4, 3'd0, g);
    checkOutput("sb_busy_set", chk_busy1, 1'b1);
    applyStimulus(3'b010, {3'd0, 3'd4, 3'd0}, {32'h0, 32'h44, 32'h0}, 1'b0, 3'd0, 3'd4, 3'd0, g);
    applyStimulus(3'b000, '0, '0, 1'b0, 3'd0, 3'd4, 3'd0, g);
    checkOutput("sb_fwd", chk_busy1, 1'b0);
    checkOutput("sb_busy4_hold", busy[4], 1'b1);
    applyStimulus(3'b000, '0, '0, 1'b0, 3'd0, 3'd4, 3'd0, g);
    checkOutput("sb_busy4_clr", busy[4], 1'b0);

    // Set/clear collision on reg 6: the reservation wins.
    applyStimulus(3'b000, '0, '0, 1'b1, 3'd6, 3'd0, 3'd0, g);
    applyStimulus(3'b001, {3'd0, 3'd0, 3'd6}, {32'h0, 32'h0, 32'h66}, 1'b0, 3'd0, 3'd0, 3'd0, g);
    applyStimulus(3'b000, '0, '0, 1'b1, 3'd6, 3'd6, 3'd0, g);
    applyStimulus(3'b000, '0, '0, 1'b0, 3'd0, 3'd6, 3'd0, g);
    checkOutput("collide_busy6", busy[6], 1'b1);

    // Asynchronous reset mid-cycle while a write is on the port.
    applyStimulus(3'b000, '0, '0, 1'b1, 3'd2, 3'd0, 3'd0, g);
    applyStimulus(3'b001, {3'd0, 3'd0, 3'd7}, {32'h0, 32'h0, 32'h77}, 1'b0, 3'd0, 3'd0, 3'd0, g);
    req_valid = 3'b111;
    @(posedge clk);
    #2;
    checkOutput("pre_rst_wen", wr_reg_en, 1'b1);
    checkOutput("pre_rst_busy2", busy[2], 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_wen", wr_reg_en, 1'b0);
    checkOutput("rst_busy", busy, '0);
    checkOutput("rst_ready", req_ready, '0);
    req_valid = '0;
    rsv_en = 1'b0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(3'b111, {3'd3, 3'd2, 3'd1}, {32'hC, 32'hB, 32'hA}, 1'b0, 3'd0, 3'd0, 3'd0, g);
    checkOutput("post_rst_grant", req_ready, 3'b001);

    // Randomized traffic; un-granted requests hold or are withdrawn.
    cv = '0;
    cr = '0;
    cd = '0;
    g = -1;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUMREQ; i++) begin
        if (cv[i] && g != i) begin
          if ($urandom_range(7) == 0) cv[i] = 1'b0;
        end else begin
          cv[i] = ($urandom_range(2) != 0);
          cr[i*REGW +: REGW] = REGW'($urandom);
          cd[i*DATAW +: DATAW] = $urandom;
        end
      end
      applyStimulus(cv, cr, cd, $urandom_range(3) == 0, REGW'($urandom),
                    REGW'($urandom), REGW'($urandom), g);
    end

`ifdef REGFILE_WR_ARB_GRANT_CNT_EN
    // Saturate requester 0's counter, then clear it during a grant.
    for (int n = 0; n < 70000; n++) begin
      @(negedge clk);
      req_valid = 3'b001;
      rsv_en = 1'b0;
    end
    @(negedge clk);
    checkOutput("cnt_sat", grant_cnt[15:0], 16'hFFFF);
    grant_cnt_clr = 1'b1;
    @(negedge clk);
    grant_cnt_clr = 1'b0;
    checkOutput("cnt_clr", grant_cnt[15:0], 16'h0000);
    req_valid = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
